// File: rtl/frame_scanout_reader.sv
// frame_scanout_reader: front-buffer scanout with RGB332 expansion and tear-free front/back swap.
// Optional SCANOUT_BORDER_EN forces a white border on the frame edge.
module frame_scanout_reader #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int ADDR_W     = 20,
    parameter int RD_LATENCY = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              display_en,
    input  logic              frame_end,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              front_buf,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [7:0]        Red,
    output logic [7:0]        Green,
    output logic [7:0]        Blue,
    output logic              pix_valid
);
    localparam logic [9:0]        H_LIM    = 10'(H_ACTIVE);
    localparam logic [9:0]        V_LIM    = 10'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(H_ACTIVE * V_ACTIVE);
    localparam logic [ADDR_W-1:0] LINE_SZ  = ADDR_W'(H_ACTIVE);

    typedef enum logic {IDLE, PENDING} state_t;

    state_t              state_q;
    logic                swap_ack_q, front_buf_q, rd_en_q, rd_en_d, vld, border;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [RD_LATENCY-1:0] vld_q;
    logic [RD_LATENCY+1:0] pv_q;
    logic [7:0]          red_q, green_q, blue_q, red_d, green_d, blue_d;

    assign rd_en_d   = display_en && DrawX < H_LIM && DrawY < V_LIM;
    assign rd_addr_d = (front_buf_q ? FRAME_SZ : '0) + ADDR_W'(DrawY) * LINE_SZ + ADDR_W'(DrawX);
    assign vld       = vld_q[RD_LATENCY-1];

`ifdef SCANOUT_BORDER_EN
    logic [RD_LATENCY:0][9:0] x_q, y_q;

    // coordinates ride alongside the read so they line up with rd_data
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= {x_q[RD_LATENCY-1:0], DrawX};
            y_q <= {y_q[RD_LATENCY-1:0], DrawY};
        end
    end

    assign border = vld && (x_q[RD_LATENCY] == 10'd0 || x_q[RD_LATENCY] == H_LIM - 10'd1 ||
                            y_q[RD_LATENCY] == 10'd0 || y_q[RD_LATENCY] == V_LIM - 10'd1);
`else
    assign border = 1'b0;
`endif

    assign red_d   = border ? 8'hFF : vld ? {rd_data[7:5], rd_data[7:5], rd_data[7:6]} : 8'h00;
    assign green_d = border ? 8'hFF : vld ? {rd_data[4:2], rd_data[4:2], rd_data[4:3]} : 8'h00;
    assign blue_d  = border ? 8'hFF : vld ? {4{rd_data[1:0]}} : 8'h00;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            vld_q     <= '0;
            pv_q      <= '0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
        end else begin
            rd_en_q <= rd_en_d;
            if (rd_en_d) rd_addr_q <= rd_addr_d;
            vld_q   <= RD_LATENCY'({vld_q, rd_en_q});
            pv_q    <= {pv_q[RD_LATENCY:0], display_en};
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    // a request seen during the ack cycle is the one just served, so it is ignored
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            swap_ack_q  <= 1'b0;
            front_buf_q <= 1'b0;
        end else begin
            swap_ack_q <= 1'b0;
            if (state_q == IDLE) begin
                if (swap_req && !swap_ack_q) state_q <= PENDING;
            end else if (frame_end) begin
                front_buf_q <= ~front_buf_q;
                swap_ack_q  <= 1'b1;
                state_q     <= IDLE;
            end
        end
    end

    assign swap_ack  = swap_ack_q;
    assign front_buf = front_buf_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign Red       = red_q;
    assign Green     = green_q;
    assign Blue      = blue_q;
    assign pix_valid = pv_q[RD_LATENCY+1];
endmodule
